// File: rtl/vdp_cpu_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_cpu_reader_pkg
//  Description : Shared constants for the VDP CPU port (reader and writer).
//                Holds the address width, the port offsets, the control-byte
//                command prefixes, the status bit index and the prefetch FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vdp_cpu_reader_pkg;

   localparam int VDP_ADDR_W = 12;

   // Port offsets, selected by the IO address LSB
   localparam logic PORT_DATA = 1'b0;
   localparam logic PORT_CTRL = 1'b1;

   // Second control byte prefix (din[7:6]); the write port decodes the same set
   localparam logic [1:0] CMD_RD_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_ADDR = 2'b01;
   localparam logic [1:0] CMD_REG     = 2'b10;

   // Bit position of the vblank flag in the status byte
   localparam int ST_VBLANK = 7;

   // Prefetch FSM encoding
   typedef enum logic [1:0] {
      PF_IDLE    = 2'd0,
      PF_FETCH   = 2'd1,
      PF_WAIT    = 2'd2,
      PF_CAPTURE = 2'd3
   } pf_state_e;

endpackage : vdp_cpu_reader_pkg
`default_nettype wire

// File: rtl/vdp_cpu_reader_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_cpu_reader_prefetch
//  Description : Read-ahead engine. On start it strobes VRAM at addr, waits
//                out the memory latency and captures the byte into the
//                read-ahead latch.
//  Ports       : phi_i/reset_i    clock, synchronous active-high reset
//                start_i          begin (or restart) a fetch at addr_i
//                addr_i           current read pointer
//                mem_rd_en_o      VRAM read strobe (FETCH state only)
//                mem_raddr_o      VRAM read address (always the pointer)
//                mem_rdata_i      VRAM data, MEM_LAT cycles after the strobe
//                busy_o           fetch in flight
//                data_o           read-ahead latch
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_cpu_reader_prefetch
   import vdp_cpu_reader_pkg::*;
#(
   parameter int ADDR_W  = VDP_ADDR_W,
   parameter int MEM_LAT = 1
) (
   input  logic              phi_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_raddr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              busy_o,
   output logic [7:0]        data_o
);

   // Number of WAIT cycles between FETCH and CAPTURE
   localparam logic [1:0] WAIT_CYC = 2'(MEM_LAT - 1);

   pf_state_e  state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;

   always_ff @(posedge phi_i) begin
      if (reset_i) begin
         state_q <= PF_IDLE;
         cnt_q   <= 2'd0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      mem_rd_en_o = 1'b0;
      busy_o      = (state_q != PF_IDLE);

      case (state_q)
         PF_IDLE: ;
         PF_FETCH: begin
            mem_rd_en_o = 1'b1;
            if (WAIT_CYC == 2'd0) begin
               state_d = PF_CAPTURE;
            end else begin
               state_d = PF_WAIT;
               cnt_d   = 2'd1;
            end
         end
         PF_WAIT: begin
            if (cnt_q == WAIT_CYC) begin
               state_d = PF_CAPTURE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         PF_CAPTURE: begin
            data_d  = mem_rdata_i;
            state_d = PF_IDLE;
         end
         default: state_d = PF_IDLE;
      endcase

      // A new start always wins: the fetch in flight is abandoned and its
      // data never reaches the latch, even if it arrives this very cycle.
      if (start_i) begin
         state_d = PF_FETCH;
         cnt_d   = 2'd0;
         data_d  = data_q;
      end
   end

   assign mem_raddr_o = addr_i;
   assign data_o      = data_q;

endmodule : vdp_cpu_reader_prefetch
`default_nettype wire

// File: rtl/vdp_cpu_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vdp_cpu_reader
//  Description : CPU read-back path of the VDP. Serves reads of the data port
//                (read-ahead buffered VRAM) and the status port, snoops
//                control writes for read-address set commands, and owns the
//                read pointer and the vblank status flag.
//  Macro       : VDP_IRQ_EN - adds irq_en_i / int_n_o (registered interrupt)
//  Ports       : phi_i/reset_i    clock, synchronous active-high reset
//                rd_tick_i        qualified IO read pulse
//                wr_tick_i        qualified IO write pulse
//                a0_i             0 = data port, 1 = control/status port
//                din_i            CPU data, sampled on wr_tick_i
//                dout_o           byte presented to the CPU bus mux
//                vblank_i         synchronised vblank level
//                mem_rd_en_o      VRAM read strobe
//                mem_raddr_o      VRAM read address
//                mem_rdata_i      VRAM read data
//                flag_clr_o       pulse: writer clears its two-byte flag
//                busy_o           prefetch in flight
//                irq_en_i         interrupt enable (VDP_IRQ_EN only)
//                int_n_o          active-low interrupt (VDP_IRQ_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module vdp_cpu_reader
   import vdp_cpu_reader_pkg::*;
#(
   parameter int ADDR_W  = VDP_ADDR_W,
   parameter int MEM_LAT = 1
) (
   input  logic              phi_i,
   input  logic              reset_i,
   input  logic              rd_tick_i,
   input  logic              wr_tick_i,
   input  logic              a0_i,
   input  logic [7:0]        din_i,
   output logic [7:0]        dout_o,
   input  logic              vblank_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_raddr_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              flag_clr_o,
   output logic              busy_o
`ifdef VDP_IRQ_EN
   ,
   input  logic              irq_en_i,
   output logic              int_n_o
`endif
);

   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              vb_flag_q, vb_flag_d;
   logic              pair_flag_q, pair_flag_d;
   logic [7:0]        lo_byte_q, lo_byte_d;
   logic              flag_clr_q, flag_clr_d;
   logic              vblank_q;
   logic              vb_rise;
   logic              start;
   logic [7:0]        ra_latch;
   logic [7:0]        status;

   always_ff @(posedge phi_i) begin
      if (reset_i) begin
         rd_ptr_q    <= '0;
         vb_flag_q   <= 1'b0;
         pair_flag_q <= 1'b0;
         lo_byte_q   <= 8'h00;
         flag_clr_q  <= 1'b0;
         vblank_q    <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         vb_flag_q   <= vb_flag_d;
         pair_flag_q <= pair_flag_d;
         lo_byte_q   <= lo_byte_d;
         flag_clr_q  <= flag_clr_d;
         vblank_q    <= vblank_i;
      end
   end

   assign vb_rise = vblank_i & ~vblank_q;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      vb_flag_d   = vb_flag_q;
      pair_flag_d = pair_flag_q;
      lo_byte_d   = lo_byte_q;
      flag_clr_d  = 1'b0;
      start       = 1'b0;

      if (rd_tick_i) begin
         if (a0_i == PORT_DATA) begin
            // CPU takes the current latch; advance and refill behind it
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            start    = 1'b1;
         end else begin
            vb_flag_d   = 1'b0;
            pair_flag_d = 1'b0;
            flag_clr_d  = 1'b1;
         end
      end

      if (wr_tick_i && (a0_i == PORT_CTRL)) begin
         if (!pair_flag_q) begin
            lo_byte_d   = din_i;
            pair_flag_d = 1'b1;
         end else begin
            pair_flag_d = 1'b0;
            if (din_i[7:6] == CMD_RD_ADDR) begin
               rd_ptr_d = ADDR_W'({din_i[3:0], lo_byte_q});
               start    = 1'b1;
            end
         end
      end

      // A vblank edge coinciding with a status-read clear must not be lost
      if (vb_rise) begin
         vb_flag_d = 1'b1;
      end
   end

   vdp_cpu_reader_prefetch #(
      .ADDR_W  (ADDR_W),
      .MEM_LAT (MEM_LAT)
   ) u_prefetch (
      .phi_i       (phi_i),
      .reset_i     (reset_i),
      .start_i     (start),
      .addr_i      (rd_ptr_q),
      .mem_rd_en_o (mem_rd_en_o),
      .mem_raddr_o (mem_raddr_o),
      .mem_rdata_i (mem_rdata_i),
      .busy_o      (busy_o),
      .data_o      (ra_latch)
   );

   always_comb begin
      status            = 8'h00;
      status[ST_VBLANK] = vb_flag_q;
   end

   assign dout_o     = (a0_i == PORT_DATA) ? ra_latch : status;
   assign flag_clr_o = flag_clr_q;

`ifdef VDP_IRQ_EN
   logic int_n_q;

   always_ff @(posedge phi_i) begin
      if (reset_i) begin
         int_n_q <= 1'b1;
      end else begin
         int_n_q <= ~(vb_flag_q & irq_en_i);
      end
   end

   assign int_n_o = int_n_q;
`endif

endmodule : vdp_cpu_reader
`default_nettype wire
